// File: rtl/level_sequencer_if.sv
// level_sequencer_if: event inputs and room/fade/status outputs of the level sequencer.
// Skip is present only when LEVEL_SKIP_EN is defined.
interface level_sequencer_if;
  logic       Frame_Tick;
  logic       Start;
  logic       Mario_Dead;
  logic       Flag_Reached;
  logic       Pipe_Req;
  logic [1:0] Pipe_Target;
  logic       Load_Done;
`ifdef LEVEL_SKIP_EN
  logic       Skip;
`endif
  logic [9:0] Level_Sel;
  logic       Load_Req;
  logic [3:0] Fade_Level;
  logic       Freeze;
  logic [1:0] Lives;
  logic       Game_Over;
  modport master (
`ifdef LEVEL_SKIP_EN
    output Skip,
`endif
    output Frame_Tick, Start, Mario_Dead, Flag_Reached, Pipe_Req, Pipe_Target, Load_Done,
    input  Level_Sel, Load_Req, Fade_Level, Freeze, Lives, Game_Over
  );
  modport slave (
`ifdef LEVEL_SKIP_EN
    input  Skip,
`endif
    input  Frame_Tick, Start, Mario_Dead, Flag_Reached, Pipe_Req, Pipe_Target, Load_Done,
    output Level_Sel, Load_Req, Fade_Level, Freeze, Lives, Game_Over
  );
endinterface

// File: rtl/level_sequencer.sv
// level_sequencer: game-flow FSM sequencing title/play/death/game-over and fade-out/load/fade-in room changes.
// LEVEL_SKIP_EN adds a Skip input acting as a lowest-priority Flag_Reached in PLAY.
module level_sequencer #(
  parameter int NUM_LEVELS   = 3,
  parameter int START_LIVES  = 3,
  parameter int FADE_DIV     = 2,
  parameter int DEATH_FRAMES = 120
) (
  input logic              Clk,
  input logic              Reset_n,
  level_sequencer_if.slave bus
);
  typedef enum logic [2:0] {TITLE, PLAY, DEATH_WAIT, FADE_OUT, LOAD, FADE_IN, GAME_OVER} state_t;
  localparam logic [9:0] MAX_LVL    = 10'(NUM_LEVELS);
  localparam logic [1:0] LIVES0     = 2'(START_LIVES);
  localparam logic [7:0] FADE_LAST  = 8'(FADE_DIV - 1);
  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
  state_t     state_q, state_d;
  logic [9:0] lvl_q, lvl_d, target_q, target_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] fade_q, fade_d;
  logic [1:0] lives_q, lives_d;
  logic       load_req_q, load_req_d, freeze_q, freeze_d, go_q, go_d;
  logic       tick, pipe_ok, skip, step;
  assign tick    = bus.Frame_Tick;
  assign pipe_ok = bus.Pipe_Req && bus.Pipe_Target != 2'd0 && {8'd0, bus.Pipe_Target} <= MAX_LVL;
  assign step    = tick && cnt_q >= FADE_LAST;
`ifdef LEVEL_SKIP_EN
  assign skip = bus.Skip;
`else
  assign skip = 1'b0;
`endif
  // A tick coinciding with an event-driven entry counts as the first tick of the new state
  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    target_d   = target_q;
    cnt_d      = cnt_q;
    fade_d     = fade_q;
    lives_d    = lives_q;
    load_req_d = load_req_q;
    case (state_q)
      TITLE: if (bus.Start) begin
        target_d = 10'd1;
        state_d  = FADE_OUT;
        cnt_d    = {7'd0, tick};
      end
      PLAY: begin
        cnt_d = {7'd0, tick};
        if (bus.Mario_Dead) state_d = DEATH_WAIT;
        else if (bus.Flag_Reached || (skip && !pipe_ok)) begin
          target_d = (lvl_q >= MAX_LVL) ? 10'd0 : lvl_q + 10'd1;
          state_d  = FADE_OUT;
        end else if (pipe_ok) begin
          target_d = {8'd0, bus.Pipe_Target};
          state_d  = FADE_OUT;
        end else cnt_d = '0;
      end
      DEATH_WAIT: if (tick) begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q >= DEATH_LAST) begin
          cnt_d   = '0;
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          if (lives_q <= 2'd1) begin
            state_d = GAME_OVER;
            fade_d  = '0;
          end else begin
            target_d = lvl_q;
            state_d  = FADE_OUT;
          end
        end
      end
      FADE_OUT: if (tick) begin
        cnt_d = step ? 8'd0 : cnt_q + 8'd1;
        if (step) begin
          fade_d = fade_q - 4'd1;
          if (fade_q == 4'd1) begin
            state_d    = LOAD;
            lvl_d      = target_q;
            load_req_d = 1'b1;
          end
        end
      end
      LOAD: if (bus.Load_Done && load_req_q) begin
        load_req_d = 1'b0;
        state_d    = FADE_IN;
        cnt_d      = {7'd0, tick};
      end
      FADE_IN: if (tick) begin
        cnt_d = step ? 8'd0 : cnt_q + 8'd1;
        if (step) begin
          fade_d = fade_q + 4'd1;
          if (fade_q == 4'd14) state_d = (lvl_q != 10'd0) ? PLAY : TITLE;
        end
      end
      GAME_OVER: if (bus.Start) begin
        lives_d    = LIVES0;
        target_d   = 10'd1;
        lvl_d      = 10'd1;
        load_req_d = 1'b1;
        state_d    = LOAD;
      end
      default: state_d = TITLE;
    endcase
    freeze_d = state_d != PLAY;
    go_d     = state_d == GAME_OVER;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q    <= TITLE;
      lvl_q      <= '0;
      target_q   <= '0;
      cnt_q      <= '0;
      fade_q     <= 4'd15;
      lives_q    <= LIVES0;
      load_req_q <= 1'b0;
      freeze_q   <= 1'b1;
      go_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
      fade_q     <= fade_d;
      lives_q    <= lives_d;
      load_req_q <= load_req_d;
      freeze_q   <= freeze_d;
      go_q       <= go_d;
    end
  assign bus.Level_Sel  = lvl_q;
  assign bus.Load_Req   = load_req_q;
  assign bus.Fade_Level = fade_q;
  assign bus.Freeze     = freeze_q;
  assign bus.Lives      = lives_q;
  assign bus.Game_Over  = go_q;
endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: directed walk through start, warps, deaths, game over, title return and async reset.
module tb_level_sequencer;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   passes = 0;
  int   total = 0;
  level_sequencer_if bus();
  level_sequencer dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic tick();
    bus.Frame_Tick = 1'b1;
    @(negedge Clk);
    bus.Frame_Tick = 1'b0;
    @(negedge Clk);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic load_done();
    bus.Load_Done = 1'b1;
    @(negedge Clk);
    bus.Load_Done = 1'b0;
    @(negedge Clk);
  endtask
  task automatic pipe(input logic [1:0] t);
    bus.Pipe_Target = t;
    bus.Pipe_Req = 1'b1;
    @(negedge Clk);
    bus.Pipe_Req = 1'b0;
    @(negedge Clk);
  endtask
  task automatic start();
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    @(negedge Clk);
  endtask
  task automatic die();
    bus.Mario_Dead = 1'b1;
    @(negedge Clk);
    bus.Mario_Dead = 1'b0;
    @(negedge Clk);
  endtask
  task automatic room(input logic [9:0] lvl, input string tag);
    ticks(30);
    chk({tag, "_sel"}, 32'(bus.Level_Sel), 32'(lvl));
    chk({tag, "_req"}, 32'(bus.Load_Req), 32'd1);
    load_done();
    ticks(30);
    chk({tag, "_fade"}, 32'(bus.Fade_Level), 32'd15);
  endtask
  initial begin
    bus.Frame_Tick = 1'b0;
    bus.Start = 1'b0;
    bus.Mario_Dead = 1'b0;
    bus.Flag_Reached = 1'b0;
    bus.Pipe_Req = 1'b0;
    bus.Pipe_Target = 2'd0;
    bus.Load_Done = 1'b0;
`ifdef LEVEL_SKIP_EN
    bus.Skip = 1'b0;
`endif
    repeat (3) @(negedge Clk);
    chk("rst_sel", 32'(bus.Level_Sel), 32'd0);
    chk("rst_req", 32'(bus.Load_Req), 32'd0);
    chk("rst_fade", 32'(bus.Fade_Level), 32'd15);
    chk("rst_freeze", 32'(bus.Freeze), 32'd1);
    chk("rst_lives", 32'(bus.Lives), 32'd3);
    chk("rst_go", 32'(bus.Game_Over), 32'd0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    // Title start: 30 ticks of fade-out, load handshake, 30 ticks of fade-in
    start();
    chk("start_freeze", 32'(bus.Freeze), 32'd1);
    ticks(29);
    chk("fo29_fade", 32'(bus.Fade_Level), 32'd1);
    chk("fo29_req", 32'(bus.Load_Req), 32'd0);
    tick();
    chk("fo30_sel", 32'(bus.Level_Sel), 32'd1);
    chk("fo30_req", 32'(bus.Load_Req), 32'd1);
    chk("fo30_fade", 32'(bus.Fade_Level), 32'd0);
    repeat (3) @(negedge Clk);
    chk("load_hold", 32'(bus.Load_Req), 32'd1);
    load_done();
    chk("load_drop", 32'(bus.Load_Req), 32'd0);
    ticks(29);
    chk("fi29_fade", 32'(bus.Fade_Level), 32'd14);
    chk("fi29_freeze", 32'(bus.Freeze), 32'd1);
    tick();
    chk("fi30_fade", 32'(bus.Fade_Level), 32'd15);
    chk("play_freeze", 32'(bus.Freeze), 32'd0);
    // Warp to 3, then an invalid warp target is ignored
    pipe(2'd3);
    chk("pipe_freeze", 32'(bus.Freeze), 32'd1);
    room(10'd3, "pipe3");
    chk("pipe3_play", 32'(bus.Freeze), 32'd0);
    pipe(2'd0);
    repeat (4) @(negedge Clk);
    chk("pipe0_freeze", 32'(bus.Freeze), 32'd0);
    chk("pipe0_sel", 32'(bus.Level_Sel), 32'd3);
    // Level 2: simultaneous death and flag, death wins
    pipe(2'd2);
    room(10'd2, "pipe2");
    bus.Mario_Dead = 1'b1;
    bus.Flag_Reached = 1'b1;
    @(negedge Clk);
    bus.Mario_Dead = 1'b0;
    bus.Flag_Reached = 1'b0;
    @(negedge Clk);
    chk("dw_freeze", 32'(bus.Freeze), 32'd1);
    ticks(119);
    chk("dw119_lives", 32'(bus.Lives), 32'd3);
    tick();
    chk("dw120_lives", 32'(bus.Lives), 32'd2);
    chk("dw120_fade", 32'(bus.Fade_Level), 32'd15);
    room(10'd2, "death1");
    chk("death1_play", 32'(bus.Freeze), 32'd0);
    die();
    ticks(120);
    chk("death2_lives", 32'(bus.Lives), 32'd1);
    room(10'd2, "death2");
    die();
    ticks(120);
    chk("go_lives", 32'(bus.Lives), 32'd0);
    chk("go_flag", 32'(bus.Game_Over), 32'd1);
    chk("go_fade", 32'(bus.Fade_Level), 32'd0);
    chk("go_freeze", 32'(bus.Freeze), 32'd1);
    die();
    chk("go_dead_ign", 32'(bus.Lives), 32'd0);
    start();
    chk("restart_lives", 32'(bus.Lives), 32'd3);
    chk("restart_sel", 32'(bus.Level_Sel), 32'd1);
    chk("restart_req", 32'(bus.Load_Req), 32'd1);
    chk("restart_go", 32'(bus.Game_Over), 32'd0);
    chk("restart_fade", 32'(bus.Fade_Level), 32'd0);
    load_done();
    ticks(30);
    chk("restart_play", 32'(bus.Freeze), 32'd0);
    // Flag on the last level returns to title
    pipe(2'd3);
    room(10'd3, "to3");
    bus.Flag_Reached = 1'b1;
    @(negedge Clk);
    bus.Flag_Reached = 1'b0;
    @(negedge Clk);
    room(10'd0, "flag3");
    chk("title_freeze", 32'(bus.Freeze), 32'd1);
    chk("title_sel", 32'(bus.Level_Sel), 32'd0);
    // Asynchronous reset while a load request is pending
    start();
    ticks(30);
    chk("pre_rst_req", 32'(bus.Load_Req), 32'd1);
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(bus.Load_Req), 32'd0);
    chk("arst_sel", 32'(bus.Level_Sel), 32'd0);
    chk("arst_fade", 32'(bus.Fade_Level), 32'd15);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
Game-flow controller that drives the 10-bit room-select bus of the level mux and sequences every room change. Level encoding on the bus: 10'd0 = title, 10'd1..10'd3 = levels. It handles title/start, pipe warps, flag completion, death and game over. Each room change runs as fade-out, room-load handshake, fade-in, and game logic is frozen for the whole transition. It sits between the game-logic/collision blocks (event sources) and the level mux / room loader / palette fade stage (consumers).

Parameters:
NUM_LEVELS, 3, highest playable level index; flag on this level returns to title
START_LIVES, 3, lives loaded at reset and on restart (1..3)
FADE_DIV, 2, Frame_Tick pulses per fade step
DEATH_FRAMES, 120, Frame_Tick pulses spent in death pause (1..255)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
Frame_Tick  in  1  one-cycle pulse per video frame (vsync-derived, Clk domain)
Start  in  1  start/restart button, level-sensitive
Mario_Dead  in  1  death event pulse from game logic
Flag_Reached  in  1  level-complete pulse
Pipe_Req  in  1  warp request pulse
Pipe_Target  in  2  destination level for Pipe_Req
Load_Done  in  1  room loader finished
Level_Sel  out  10  room select to level mux (0..NUM_LEVELS)
Load_Req  out  1  room-load request, held until accepted
Fade_Level  out  4  brightness, 0 = black, 15 = full
Freeze  out  1  halts player/enemy logic
Lives  out  2  remaining lives
Game_Over  out  1  high in GAME_OVER state

Behaviour:
- Single clock Clk. Reset is asynchronous and active-low on Reset_n. All outputs are registered.
- Reset values (also applied immediately on Reset_n low mid-transition): state TITLE, Level_Sel=0, Load_Req=0, Fade_Level=15, Freeze=1, Lives=START_LIVES, Game_Over=0, internal target=0, counters=0.
- Freeze=1 in every state except PLAY.
- States and transitions:
  - TITLE: on Start=1, set target=1 and go to FADE_OUT.
  - PLAY: event priority in the same cycle is Mario_Dead > Flag_Reached > Pipe_Req.
    - Mario_Dead: go to DEATH_WAIT.
    - Flag_Reached: target = Level_Sel+1, or 0 if Level_Sel==NUM_LEVELS; go to FADE_OUT.
    - Pipe_Req: accepted only if Pipe_Target is in 1..NUM_LEVELS, then target=Pipe_Target and go to FADE_OUT. A target of 0 or above NUM_LEVELS is ignored and the state stays in PLAY.
  - DEATH_WAIT: counts Frame_Tick pulses. On the DEATH_FRAMES-th pulse, Lives decrements. If Lives was 1, Lives=0 and go to GAME_OVER. Otherwise target=Level_Sel and go to FADE_OUT.
  - FADE_OUT: every FADE_DIV Frame_Tick pulses, Fade_Level decrements by 1. In the cycle it reaches 0, go to LOAD. Duration = 15*FADE_DIV ticks.
  - LOAD: Level_Sel=target and Load_Req=1 on the first LOAD cycle. Load_Req stays at 1 until Load_Done is sampled while Load_Req=1. In that cycle Load_Req drops and the state goes to FADE_IN. No timeout; Fade_Level stays at 0.
  - FADE_IN: every FADE_DIV ticks, Fade_Level increments by 1. On reaching 15, go to PLAY if Level_Sel!=0, otherwise to TITLE.
  - GAME_OVER: Game_Over=1, Fade_Level=0. On Start=1: Lives=START_LIVES, target=1, Game_Over=0, and go straight to LOAD (no fade-out).
- Event inputs (Mario_Dead, Flag_Reached, Pipe_Req) are ignored outside PLAY.
- Start is ignored outside TITLE and GAME_OVER.
- Load_Done is ignored outside LOAD.
- Frame_Tick arriving in the same cycle as a state change counts for the new state only if that state is DEATH_WAIT/FADE_*; it is not counted for the state being left.
- Level_Sel never takes a value above NUM_LEVELS. Lives never underflows below 0.

Optional Feature:
LEVEL_SKIP_EN
- When defined: adds input Skip (1 bit). In PLAY, Skip=1 is treated exactly as Flag_Reached, at the lowest priority (below Pipe_Req).
- When not defined: the Skip port does not exist and there is no skip path.

Test Plan:
- Reset_n low, then release; pulse Start -> 15*FADE_DIV ticks later Level_Sel=1 and Load_Req=1; Load_Done 3 cycles later -> Load_Req=0; after 15*FADE_DIV more ticks Fade_Level=15 and Freeze=0.
- In PLAY on level 1, Pipe_Req with Pipe_Target=3 -> transition ends with Level_Sel=3. A second Pipe_Req with Pipe_Target=0 -> ignored, Freeze stays 0.
- Mario_Dead and Flag_Reached in the same cycle on level 2 -> DEATH_WAIT. After 120 ticks Lives goes 3->2 and Level_Sel reloads 2.
- Three deaths from START_LIVES=3 -> Lives=0, Game_Over=1, Fade_Level=0. Start -> Lives=3, Level_Sel=1, Load_Req=1 without any fade-out.
- Flag_Reached on level 3 -> Level_Sel=0, state ends in TITLE with Freeze=1 and Fade_Level=15.
- Reset_n pulsed low during LOAD with Load_Req=1 -> Load_Req=0, Level_Sel=0 and Fade_Level=15 immediately, without waiting for a Clk edge.
